// File: rtl/mem_arbiter_if.sv
// Bundle of the CPU-side request ports and memory-side bus of the memory arbiter.
// The master modport is the arbiter's view; slave is the pipeline/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              inst_req_i;
  logic [ADDR_W-1:0] inst_addr_i;
  logic [DATA_W-1:0] inst_rdata_o;
  logic              inst_ack_o;

  logic              data_req_i;
  logic              data_we_i;
  logic [ADDR_W-1:0] data_addr_i;
  logic [DATA_W-1:0] data_wdata_i;
  logic [3:0]        data_sel_i;
  logic [DATA_W-1:0] data_rdata_o;
  logic              data_ack_o;

  logic              mem_ce_o;
  logic              mem_we_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [3:0]        mem_sel_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ready_i;

  logic              stallreq_o;

  modport master (
    input  inst_req_i, inst_addr_i,
    output inst_rdata_o, inst_ack_o,
    input  data_req_i, data_we_i, data_addr_i, data_wdata_i, data_sel_i,
    output data_rdata_o, data_ack_o,
    output mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    input  mem_rdata_i, mem_ready_i,
    output stallreq_o
  );

  modport slave (
    output inst_req_i, inst_addr_i,
    input  inst_rdata_o, inst_ack_o,
    output data_req_i, data_we_i, data_addr_i, data_wdata_i, data_sel_i,
    input  data_rdata_o, data_ack_o,
    input  mem_ce_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_sel_o,
    output mem_rdata_i, mem_ready_i,
    input  stallreq_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch and load/store.
// Data normally wins; a fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.master bus
);
  localparam int                CNT_W     = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(STARVE_MAX);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = '0;
  localparam logic [DATA_W-1:0] ZERO_DATA = '0;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             owner_inst;
  logic             inst_wins;

  always_comb inst_wins = bus.inst_req_i && (!bus.data_req_i || starve_cnt == CNT_MAX);

  // NOTE: every register here is assigned with <= so all state advances together
  // on the edge and no branch observes another branch's same-cycle update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      starve_cnt       <= '0;
      owner_inst       <= 1'b0;
      bus.mem_ce_o     <= 1'b0;
      bus.mem_we_o     <= 1'b0;
      bus.mem_addr_o   <= ZERO_ADDR;
      bus.mem_wdata_o  <= ZERO_DATA;
      bus.mem_sel_o    <= 4'b0000;
      bus.inst_ack_o   <= 1'b0;
      bus.data_ack_o   <= 1'b0;
      // NOTE: the read-data registers are reset as well, because they are visible
      // outputs that must read as zero straight out of reset.
      bus.inst_rdata_o <= ZERO_DATA;
      bus.data_rdata_o <= ZERO_DATA;
    end else begin
      case (state)
        IDLE: begin
          if (bus.inst_req_i || bus.data_req_i) begin
            bus.mem_ce_o <= 1'b1;
            owner_inst   <= inst_wins;
            state        <= BUSY;
            if (inst_wins) begin
              bus.mem_we_o    <= 1'b0;
              bus.mem_addr_o  <= bus.inst_addr_i;
              bus.mem_wdata_o <= ZERO_DATA;
              bus.mem_sel_o   <= 4'b1111;
              starve_cnt      <= '0;
            end else begin
              bus.mem_we_o    <= bus.data_we_i;
              bus.mem_addr_o  <= bus.data_addr_i;
              bus.mem_wdata_o <= bus.data_wdata_i;
              bus.mem_sel_o   <= bus.data_sel_i;
              // Count data grants that overtook a waiting fetch.
              if (!bus.inst_req_i)          starve_cnt <= '0;
              else if (starve_cnt != CNT_MAX) starve_cnt <= starve_cnt + 1'b1;
            end
          end
        end

        BUSY: begin
          if (bus.mem_ready_i) begin
            if (owner_inst) begin
              bus.inst_rdata_o <= bus.mem_rdata_i;
              bus.inst_ack_o   <= 1'b1;
            end else begin
              bus.data_rdata_o <= bus.mem_rdata_i;
              bus.data_ack_o   <= 1'b1;
            end
            bus.mem_ce_o  <= 1'b0;
            bus.mem_we_o  <= 1'b0;
            bus.mem_sel_o <= 4'b0000;
            state         <= DONE;
          end
        end

        DONE: begin
          // Requesters still show the completed req here, so no grant this cycle.
          bus.inst_ack_o <= 1'b0;
          bus.data_ack_o <= 1'b0;
          state          <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.stallreq_o = (bus.inst_req_i & ~bus.inst_ack_o) |
                          (bus.data_req_i & ~bus.data_ack_o);
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized run
// against a transaction-level model of the arbitration and timing rules.
module tb_mem_arbiter;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;
  localparam int OUT_W      = 3 * DATA_W + ADDR_W + 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks   = 0;
  int   failures = 0;

  mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [OUT_W-1:0] outs();
    return {bus.inst_rdata_o, bus.inst_ack_o, bus.data_rdata_o, bus.data_ack_o,
            bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o,
            bus.mem_sel_o, bus.stallreq_o};
  endfunction

  task automatic idle_inputs();
    bus.inst_req_i   = 1'b0;
    bus.inst_addr_i  = '0;
    bus.data_req_i   = 1'b0;
    bus.data_we_i    = 1'b0;
    bus.data_addr_i  = '0;
    bus.data_wdata_i = '0;
    bus.data_sel_i   = 4'b0000;
    bus.mem_rdata_i  = '0;
    bus.mem_ready_i  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got %h expected 0", outs());
    end
    rst = 1'b0;
    tick();
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL post_reset_idle: got %h expected 0", outs());
    end
  endtask

  task automatic test_single_fetch();
    do_reset();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'h3401_1100;
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 32'h0000_0040;
    #1;
    checks++;
    if (bus.stallreq_o !== 1'b1) begin
      failures++;
      $display("FAIL fetch_stall_req_cycle: got %b expected 1", bus.stallreq_o);
    end
    tick();
    checks++;
    if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.stallreq_o}
        !== {1'b1, 1'b0, 32'h40, 4'b1111, 1'b1}) begin
      failures++;
      $display("FAIL fetch_grant: ce=%b we=%b addr=%h sel=%b stall=%b expected 1 0 40 1111 1",
               bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_sel_o, bus.stallreq_o);
    end
    tick();
    checks++;
    if ({bus.inst_ack_o, bus.inst_rdata_o, bus.stallreq_o, bus.mem_ce_o}
        !== {1'b1, 32'h3401_1100, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL fetch_ack: ack=%b rdata=%h stall=%b ce=%b expected 1 34011100 0 0",
               bus.inst_ack_o, bus.inst_rdata_o, bus.stallreq_o, bus.mem_ce_o);
    end
    bus.inst_req_i = 1'b0;
    tick();
    checks++;
    if ({bus.inst_ack_o, bus.mem_ce_o, bus.inst_rdata_o} !== {1'b0, 1'b0, 32'h3401_1100}) begin
      failures++;
      $display("FAIL fetch_ack_pulse: ack=%b ce=%b rdata=%h expected 0 0 34011100",
               bus.inst_ack_o, bus.mem_ce_o, bus.inst_rdata_o);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    bus.mem_ready_i = 1'b1;
    bus.mem_rdata_i = 32'hAAAA_0001;
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 32'h44;
    bus.data_req_i  = 1'b1;
    bus.data_we_i   = 1'b0;
    bus.data_addr_i = 32'h100;
    bus.data_sel_i  = 4'b1111;
    tick();
    checks++;
    if ({bus.mem_ce_o, bus.mem_addr_o} !== {1'b1, 32'h100}) begin
      failures++;
      $display("FAIL simul_first_grant: ce=%b addr=%h expected 1 100", bus.mem_ce_o, bus.mem_addr_o);
    end
    tick();
    checks++;
    if ({bus.data_ack_o, bus.data_rdata_o, bus.inst_ack_o, bus.stallreq_o}
        !== {1'b1, 32'hAAAA_0001, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL simul_data_ack: dack=%b drdata=%h iack=%b stall=%b expected 1 aaaa0001 0 1",
               bus.data_ack_o, bus.data_rdata_o, bus.inst_ack_o, bus.stallreq_o);
    end
    bus.data_req_i  = 1'b0;
    bus.mem_rdata_i = 32'hBBBB_0002;
    tick();
    tick();
    checks++;
    if ({bus.mem_ce_o, bus.mem_addr_o, bus.mem_sel_o} !== {1'b1, 32'h44, 4'b1111}) begin
      failures++;
      $display("FAIL simul_second_grant: ce=%b addr=%h sel=%b expected 1 44 1111",
               bus.mem_ce_o, bus.mem_addr_o, bus.mem_sel_o);
    end
    tick();
    checks++;
    if ({bus.inst_ack_o, bus.inst_rdata_o, bus.data_ack_o} !== {1'b1, 32'hBBBB_0002, 1'b0}) begin
      failures++;
      $display("FAIL simul_inst_ack: iack=%b irdata=%h dack=%b expected 1 bbbb0002 0",
               bus.inst_ack_o, bus.inst_rdata_o, bus.data_ack_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_wait_states();
    logic [ADDR_W+DATA_W+5:0] held;
    held = {1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011};
    do_reset();
    bus.data_req_i   = 1'b1;
    bus.data_we_i    = 1'b1;
    bus.data_addr_i  = 32'h200;
    bus.data_wdata_i = 32'hDEAD_BEEF;
    bus.data_sel_i   = 4'b0011;
    tick();
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      checks++;
      if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o,
           bus.data_ack_o} !== {held, 1'b0}) begin
        failures++;
        $display("FAIL wait_hold_%0d: got %h expected %h", i,
                 {bus.mem_ce_o, bus.mem_we_o, bus.mem_addr_o, bus.mem_wdata_o, bus.mem_sel_o,
                  bus.data_ack_o}, {held, 1'b0});
      end
    end
    bus.mem_ready_i = 1'b1;
    tick();
    checks++;
    if ({bus.data_ack_o, bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o} !== {1'b1, 1'b0, 1'b0, 4'b0000}) begin
      failures++;
      $display("FAIL wait_ack: dack=%b ce=%b we=%b sel=%b expected 1 0 0 0000",
               bus.data_ack_o, bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_starvation();
    logic [5:0] seq;
    int         n;
    seq = '0;
    n   = 0;
    do_reset();
    bus.mem_ready_i = 1'b1;
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 32'h80;
    bus.data_req_i  = 1'b1;
    bus.data_addr_i = 32'h1000;
    bus.data_sel_i  = 4'b1111;
    for (int c = 0; c < 60 && n < 6; c++) begin
      tick();
      if (bus.inst_ack_o || bus.data_ack_o) begin
        seq = {bus.inst_ack_o, seq[5:1]};
        n++;
        if (bus.data_ack_o) bus.data_addr_i = bus.data_addr_i + 32'd4;
      end
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL starve_timeout: got %0d grants expected 6", n);
    end
    checks++;
    if (seq !== 6'b010000) begin
      failures++;
      $display("FAIL starve_order: got %b expected 010000 (bit0 first, 1=fetch)", seq);
    end
    idle_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_access();
    logic stray;
    int   waited;
    stray = 1'b0;
    do_reset();
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 32'h300;
    tick();
    tick();
    checks++;
    if (bus.mem_ce_o !== 1'b1) begin
      failures++;
      $display("FAIL midrst_busy: ce=%b expected 1", bus.mem_ce_o);
    end
    rst = 1'b1;
    bus.inst_req_i = 1'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (outs() !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: got %h expected 0", outs());
    end
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.inst_ack_o || bus.data_ack_o || bus.mem_ce_o) stray = 1'b1;
    end
    checks++;
    if (stray !== 1'b0) begin
      failures++;
      $display("FAIL midrst_no_ack: got activity=%b expected 0", stray);
    end
    bus.inst_req_i  = 1'b1;
    bus.inst_addr_i = 32'h304;
    bus.mem_rdata_i = 32'hC0FF_EE01;
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!bus.inst_ack_o && waited < 8);
    checks++;
    if ({bus.inst_ack_o, bus.inst_rdata_o} !== {1'b1, 32'hC0FF_EE01} || waited != 2) begin
      failures++;
      $display("FAIL midrst_fresh_fetch: ack=%b rdata=%h after %0d cycles expected 1 c0ffee01 after 2",
               bus.inst_ack_o, bus.inst_rdata_o, waited);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stray_ready();
    do_reset();
    bus.mem_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.mem_rdata_i = $urandom;
      tick();
      checks++;
      if ({bus.mem_ce_o, bus.inst_ack_o, bus.data_ack_o, bus.inst_rdata_o, bus.data_rdata_o} !== '0) begin
        failures++;
        $display("FAIL stray_ready_%0d: ce=%b iack=%b dack=%b expected all 0 with zero rdata",
                 i, bus.mem_ce_o, bus.inst_ack_o, bus.data_ack_o);
      end
    end
    idle_inputs();
  endtask

  // Transaction model: an access occupies the memory until ready, the completing
  // requester sees one ack cycle, and one quiet cycle follows before the next grant.
  task automatic test_random();
    bit              in_flight, quiet, own_inst, x_we, drd_known;
    bit              e_iack, e_dack;
    int              data_streak;
    logic [ADDR_W-1:0] x_addr;
    logic [DATA_W-1:0] x_wdata, e_irdata, e_drdata;
    logic [3:0]      x_sel;
    in_flight = 0; quiet = 0; own_inst = 0; x_we = 0; drd_known = 1;
    data_streak = 0; x_addr = '0; x_wdata = '0; x_sel = '0;
    e_irdata = '0; e_drdata = '0;
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      e_iack = 0;
      e_dack = 0;
      if (in_flight) begin
        if (bus.mem_ready_i) begin
          in_flight = 0;
          quiet     = 1;
          if (own_inst) begin
            e_iack   = 1;
            e_irdata = bus.mem_rdata_i;
          end else begin
            e_dack    = 1;
            drd_known = !x_we;
            e_drdata  = bus.mem_rdata_i;
          end
        end
      end else if (quiet) begin
        quiet = 0;
      end else if (bus.inst_req_i || bus.data_req_i) begin
        own_inst  = bus.inst_req_i && (!bus.data_req_i || data_streak >= STARVE_MAX);
        in_flight = 1;
        if (own_inst) begin
          x_addr = bus.inst_addr_i; x_we = 0; x_sel = 4'b1111;
          data_streak = 0;
        end else begin
          x_addr = bus.data_addr_i; x_we = bus.data_we_i;
          x_wdata = bus.data_wdata_i; x_sel = bus.data_sel_i;
          data_streak = bus.inst_req_i ? data_streak + 1 : 0;
        end
      end
      checks++;
      if ({bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o} !==
          {in_flight, in_flight & x_we, in_flight ? x_sel : 4'b0000}) begin
        failures++;
        $display("FAIL rand_ctrl cyc%0d: ce=%b we=%b sel=%b expected %b %b %b", cyc,
                 bus.mem_ce_o, bus.mem_we_o, bus.mem_sel_o, in_flight, in_flight & x_we,
                 in_flight ? x_sel : 4'b0000);
      end
      if (in_flight) begin
        checks++;
        if (bus.mem_addr_o !== x_addr || (!own_inst && bus.mem_wdata_o !== x_wdata)) begin
          failures++;
          $display("FAIL rand_bus cyc%0d: addr=%h wdata=%h expected %h %h", cyc,
                   bus.mem_addr_o, bus.mem_wdata_o, x_addr, x_wdata);
        end
      end
      checks++;
      if ({bus.inst_ack_o, bus.data_ack_o, bus.inst_rdata_o} !== {e_iack, e_dack, e_irdata}) begin
        failures++;
        $display("FAIL rand_ack cyc%0d: iack=%b dack=%b irdata=%h expected %b %b %h", cyc,
                 bus.inst_ack_o, bus.data_ack_o, bus.inst_rdata_o, e_iack, e_dack, e_irdata);
      end
      if (drd_known) begin
        checks++;
        if (bus.data_rdata_o !== e_drdata) begin
          failures++;
          $display("FAIL rand_drdata cyc%0d: got %h expected %h", cyc, bus.data_rdata_o, e_drdata);
        end
      end
      // Requesters may change only when idle or once their ack is visible.
      if (!bus.inst_req_i || bus.inst_ack_o) begin
        bus.inst_req_i  = ($urandom_range(0, 2) != 0);
        bus.inst_addr_i = 32'($urandom_range(0, 1023)) << 2;
      end
      if (!bus.data_req_i || bus.data_ack_o) begin
        bus.data_req_i   = ($urandom_range(0, 2) != 0);
        bus.data_we_i    = 1'($urandom_range(0, 1));
        bus.data_addr_i  = 32'($urandom_range(0, 1023)) << 2;
        bus.data_wdata_i = $urandom;
        bus.data_sel_i   = 4'($urandom_range(0, 15));
      end
      bus.mem_ready_i = ($urandom_range(0, 3) != 0);
      bus.mem_rdata_i = $urandom;
      #1;
      checks++;
      if (bus.stallreq_o !== ((bus.inst_req_i & ~e_iack) | (bus.data_req_i & ~e_dack))) begin
        failures++;
        $display("FAIL rand_stall cyc%0d: got %b expected %b", cyc, bus.stallreq_o,
                 (bus.inst_req_i & ~e_iack) | (bus.data_req_i & ~e_dack));
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_wait_states();
    test_starvation();
    test_reset_mid_access();
    test_stray_ready();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
